qpmm_sched: RTL

- Round-robin scheduler that shares one fully pipelined QPMM Montgomery multiplier among NUM_REQ requesters.
- Accepts at most one operand pair per cycle and drives it into the multiplier.
- Tracks the requester ID of every in-flight operation in a tag delay line matched to the multiplier latency, and routes each result back to its requester.
- Bounds per-requester outstanding operations; supports a drain handshake so the Fp tower controller can quiesce the multiplier.

---
 rtl/qpmm_sched_pkg.sv | 21 ++
 rtl/qpmm_rr_arb.sv | 36 +++
 rtl/qpmm_sched.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/qpmm_sched_pkg.sv
// PARAMS_BN254_d0: shared BN254 field types and latency constants.
//   qpmm_fp_t      - one BN254 base-field element.
//   QPMM_LAT       - cycles from QPMM operands to result (pipeline + final add).
//   sched_state_e  - drain state machine encoding for qpmm_sched.
package PARAMS_BN254_d0;

  localparam int QPMM_FP_W = 254;
  typedef logic [QPMM_FP_W-1:0] qpmm_fp_t;

  // Multiplier core depth plus the trailing conditional-subtract adder.
  localparam int QPMM_MUL_DEPTH = 20;
  localparam int QPMM_ADD_LAT   = 2;
  localparam int QPMM_LAT       = QPMM_MUL_DEPTH + QPMM_ADD_LAT;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_DRAINED
  } sched_state_e;

endpackage

// File: rtl/qpmm_rr_arb.sv
// qpmm_rr_arb: combinational round-robin arbiter.
//   elig     in  NUM_REQ  requesters allowed to win this cycle
//   rr_ptr   in  ID_W     last winner; search starts at rr_ptr+1
//   grant    out NUM_REQ  one-hot winner (all zero when nobody is eligible)
//   grant_id out ID_W     encoded winner (0 when nobody is eligible)
module qpmm_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] elig,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);

  int   idx;
  logic found;

  // Walk the ring starting just after the previous winner; the first
  // eligible index wins, so the last winner has the lowest priority.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && elig[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/qpmm_sched.sv
// qpmm_sched: shares one fully pipelined QPMM multiplier among NUM_REQ
// requesters with round-robin arbitration, per-requester credit limits and
// a drain handshake.
//   clk, rstn   clock and asynchronous active-low reset
//   req_valid   per-requester operand valid
//   req_a/req_b per-requester operands
//   req_ready   one-hot grant (combinational)
//   mul_a/mul_b registered operands to the multiplier
//   mul_z       multiplier result, PIPE_LAT cycles after mul_a/mul_b
//   rsp_valid   one-hot result strobe, no backpressure
//   rsp_data    result shared by all requesters
//   drain_req   level request to stop issuing
//   drained     drained state reached and nothing in flight
//   busy        something is in flight
module qpmm_sched
  import PARAMS_BN254_d0::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int PIPE_LAT = QPMM_LAT,
  parameter int MAX_OUT  = 8,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic     [NUM_REQ-1:0] req_valid,
  input  qpmm_fp_t [NUM_REQ-1:0] req_a,
  input  qpmm_fp_t [NUM_REQ-1:0] req_b,
  output logic     [NUM_REQ-1:0] req_ready,
  output qpmm_fp_t               mul_a,
  output qpmm_fp_t               mul_b,
  input  qpmm_fp_t               mul_z,
  output logic     [NUM_REQ-1:0] rsp_valid,
  output qpmm_fp_t               rsp_data,
  input  logic                   drain_req,
  output logic                   drained,
  output logic                   busy
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);

  sched_state_e state_q, state_d;

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] retire_hot;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W-1:0]    rr_ptr;
  logic               issue;
  logic [CNT_W-1:0]   out_cnt [NUM_REQ];

  // Tag line: entry 0 is written together with mul_a/mul_b, so entry
  // PIPE_LAT lines up with mul_z for the same operation.
  logic [PIPE_LAT:0]  tag_vld;
  logic [ID_W-1:0]    tag_id [PIPE_LAT+1];

  assign busy      = |tag_vld;
  assign drained   = (state_q == ST_DRAINED) && !busy;
  assign issue     = |grant;
  assign req_ready = grant;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid[i] && (out_cnt[i] < CNT_W'(MAX_OUT)) && (state_q == ST_RUN);
    end
  end

  qpmm_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .elig     (elig),
    .rr_ptr   (rr_ptr),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // Requester whose result leaves the tag line this cycle.
  always_comb begin
    retire_hot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      retire_hot[i] = tag_vld[PIPE_LAT] && (tag_id[PIPE_LAT] == ID_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Dropping drain_req always wins, so an aborted drain returns to RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:     if (drain_req) state_d = ST_DRAIN;
      ST_DRAIN:   if (!drain_req) state_d = ST_RUN;
                  else if (!busy) state_d = ST_DRAINED;
      ST_DRAINED: if (!drain_req) state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr <= ID_W'(NUM_REQ - 1);
      mul_a  <= '0;
      mul_b  <= '0;
    end else if (issue) begin
      rr_ptr <= grant_id;
      mul_a  <= req_a[grant_id];
      mul_b  <= req_b[grant_id];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_vld <= '0;
      for (int k = 0; k <= PIPE_LAT; k++) tag_id[k] <= '0;
    end else begin
      tag_vld   <= {tag_vld[PIPE_LAT-1:0], issue};
      tag_id[0] <= grant_id;
      for (int k = 1; k <= PIPE_LAT; k++) tag_id[k] <= tag_id[k-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= retire_hot;
      if (tag_vld[PIPE_LAT]) rsp_data <= mul_z;
    end
  end

  // A credit returns on the edge that raises rsp_valid, so a requester at
  // its limit can be granted again in the same cycle its response appears.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_REQ; i++) out_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        case ({grant[i], retire_hot[i]})
          2'b10:   out_cnt[i] <= out_cnt[i] + 1'b1;
          2'b01:   out_cnt[i] <= out_cnt[i] - 1'b1;
          default: out_cnt[i] <= out_cnt[i];
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_chk
    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
      !(grant[g] && !retire_hot[g] && out_cnt[g] == CNT_W'(MAX_OUT)));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rstn)
      !(retire_hot[g] && !grant[g] && out_cnt[g] == '0));
  end

endmodule
